// File: rtl/pico_axi_ram_responder.sv
// AXI4 INCR-burst responder backed by a read-first block RAM.
// Independent write and read engines each keep one burst in flight.
module pico_axi_ram_responder #(
    parameter int C_AXI_ID_WIDTH   = 8,
    parameter int C_AXI_ADDR_WIDTH = 32,
    parameter int C_AXI_DATA_WIDTH = 256,
    parameter int LOG_DEPTH        = 10
) (
    input  logic                          aclk,
    input  logic                          aresetn,
    input  logic [C_AXI_ID_WIDTH-1:0]     s_axi_awid,
    input  logic [C_AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic [7:0]                    s_axi_awlen,
    input  logic                          s_axi_awvalid,
    output logic                          s_axi_awready,
    input  logic [C_AXI_DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [C_AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
    input  logic                          s_axi_wlast,
    input  logic                          s_axi_wvalid,
    output logic                          s_axi_wready,
    output logic [C_AXI_ID_WIDTH-1:0]     s_axi_bid,
    output logic [1:0]                    s_axi_bresp,
    output logic                          s_axi_bvalid,
    input  logic                          s_axi_bready,
    input  logic [C_AXI_ID_WIDTH-1:0]     s_axi_arid,
    input  logic [C_AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic [7:0]                    s_axi_arlen,
    input  logic                          s_axi_arvalid,
    output logic                          s_axi_arready,
    output logic [C_AXI_ID_WIDTH-1:0]     s_axi_rid,
    output logic [C_AXI_DATA_WIDTH-1:0]   s_axi_rdata,
    output logic [1:0]                    s_axi_rresp,
    output logic                          s_axi_rlast,
    output logic                          s_axi_rvalid,
    input  logic                          s_axi_rready
);

    localparam int ADDR_LSB = $clog2(C_AXI_DATA_WIDTH/8);
    localparam int STRB_W   = C_AXI_DATA_WIDTH/8;
    localparam int DEPTH    = 1 << LOG_DEPTH;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

    logic [C_AXI_DATA_WIDTH-1:0] mem [DEPTH];

    w_state_t                  w_state_q, w_state_d;
    logic                      awready_q, awready_d;
    logic                      wready_q, wready_d;
    logic                      bvalid_q, bvalid_d;
    logic [1:0]                bresp_q, bresp_d;
    logic [C_AXI_ID_WIDTH-1:0] bid_q, bid_d;
    logic [LOG_DEPTH-1:0]      w_idx_q, w_idx_d;
    logic [7:0]                w_cnt_q, w_cnt_d;
    logic                      w_err_q, w_err_d;
    logic                      ram_we;
    logic                      w_last_beat;
    logic                      w_beat_err;

    r_state_t                  r_state_q, r_state_d;
    logic                      arready_q, arready_d;
    logic                      rvalid_q, rvalid_d;
    logic                      rlast_q, rlast_d;
    logic [C_AXI_ID_WIDTH-1:0] rid_q, rid_d;
    logic [LOG_DEPTH-1:0]      r_idx_q, r_idx_d;
    logic [8:0]                r_left_q, r_left_d;
    logic                      rd_en;
    logic [C_AXI_DATA_WIDTH-1:0] rdata_q;

    // Write engine: the burst always runs awlen+1 beats; a misplaced wlast only flags SLVERR.
    always_comb begin
        w_state_d   = w_state_q;
        awready_d   = awready_q;
        wready_d    = wready_q;
        bvalid_d    = bvalid_q;
        bresp_d     = bresp_q;
        bid_d       = bid_q;
        w_idx_d     = w_idx_q;
        w_cnt_d     = w_cnt_q;
        w_err_d     = w_err_q;
        ram_we      = 1'b0;
        w_last_beat = (w_cnt_q == 8'd0);
        w_beat_err  = (s_axi_wlast != w_last_beat);
        case (w_state_q)
            W_IDLE: begin
                if (s_axi_awvalid && awready_q) begin
                    w_state_d = W_DATA;
                    awready_d = 1'b0;
                    wready_d  = 1'b1;
                    bid_d     = s_axi_awid;
                    w_idx_d   = s_axi_awaddr[ADDR_LSB +: LOG_DEPTH];
                    w_cnt_d   = s_axi_awlen;
                    w_err_d   = 1'b0;
                end
            end
            W_DATA: begin
                if (s_axi_wvalid) begin
                    ram_we  = 1'b1;
                    w_idx_d = w_idx_q + {{(LOG_DEPTH-1){1'b0}}, 1'b1};
                    w_cnt_d = w_cnt_q - 8'd1;
                    w_err_d = w_err_q | w_beat_err;
                    if (w_last_beat) begin
                        w_state_d = W_RESP;
                        wready_d  = 1'b0;
                        bvalid_d  = 1'b1;
                        bresp_d   = (w_err_q | w_beat_err) ? 2'b10 : 2'b00;
                    end
                end
            end
            W_RESP: begin
                if (s_axi_bready) begin
                    w_state_d = W_IDLE;
                    bvalid_d  = 1'b0;
                    awready_d = 1'b1;
                end
            end
            default: begin
                w_state_d = W_IDLE;
                awready_d = 1'b1;
                wready_d  = 1'b0;
                bvalid_d  = 1'b0;
            end
        endcase
    end

    // Read engine: the output register is reloaded whenever it is empty or being consumed.
    always_comb begin
        r_state_d = r_state_q;
        arready_d = arready_q;
        rvalid_d  = rvalid_q;
        rlast_d   = rlast_q;
        rid_d     = rid_q;
        r_idx_d   = r_idx_q;
        r_left_d  = r_left_q;
        rd_en     = 1'b0;
        case (r_state_q)
            R_IDLE: begin
                if (s_axi_arvalid && arready_q) begin
                    r_state_d = R_DATA;
                    arready_d = 1'b0;
                    rid_d     = s_axi_arid;
                    r_idx_d   = s_axi_araddr[ADDR_LSB +: LOG_DEPTH];
                    r_left_d  = {1'b0, s_axi_arlen} + 9'd1;
                end
            end
            R_DATA: begin
                if ((!rvalid_q || s_axi_rready) && (r_left_q != 9'd0)) begin
                    rd_en    = 1'b1;
                    rvalid_d = 1'b1;
                    rlast_d  = (r_left_q == 9'd1);
                    r_idx_d  = r_idx_q + {{(LOG_DEPTH-1){1'b0}}, 1'b1};
                    r_left_d = r_left_q - 9'd1;
                end else if (rvalid_q && s_axi_rready) begin
                    r_state_d = R_IDLE;
                    rvalid_d  = 1'b0;
                    rlast_d   = 1'b0;
                    arready_d = 1'b1;
                end
            end
            default: begin
                r_state_d = R_IDLE;
                arready_d = 1'b1;
                rvalid_d  = 1'b0;
                rlast_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            w_state_q <= W_IDLE;
            awready_q <= 1'b1;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= 2'b00;
            bid_q     <= '0;
            w_idx_q   <= '0;
            w_cnt_q   <= 8'd0;
            w_err_q   <= 1'b0;
            r_state_q <= R_IDLE;
            arready_q <= 1'b1;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rid_q     <= '0;
            r_idx_q   <= '0;
            r_left_q  <= 9'd0;
        end else begin
            w_state_q <= w_state_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            bid_q     <= bid_d;
            w_idx_q   <= w_idx_d;
            w_cnt_q   <= w_cnt_d;
            w_err_q   <= w_err_d;
            r_state_q <= r_state_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rlast_q   <= rlast_d;
            rid_q     <= rid_d;
            r_idx_q   <= r_idx_d;
            r_left_q  <= r_left_d;
        end
    end

    // Read-first RAM: a same-edge write to the word being read is not visible until the next read.
    always_ff @(posedge aclk) begin
        if (ram_we && aresetn) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (s_axi_wstrb[b]) begin
                    mem[w_idx_q][b*8 +: 8] <= s_axi_wdata[b*8 +: 8];
                end
            end
        end
        if (rd_en && aresetn) begin
            rdata_q <= mem[r_idx_q];
        end
    end

    assign s_axi_awready = awready_q;
    assign s_axi_wready  = wready_q;
    assign s_axi_bvalid  = bvalid_q;
    assign s_axi_bresp   = bresp_q;
    assign s_axi_bid     = bid_q;
    assign s_axi_arready = arready_q;
    assign s_axi_rvalid  = rvalid_q;
    assign s_axi_rlast   = rlast_q;
    assign s_axi_rid     = rid_q;
    assign s_axi_rdata   = rdata_q;
    assign s_axi_rresp   = 2'b00;

    logic unused_addr_bits;
    assign unused_addr_bits = ^{s_axi_awaddr[C_AXI_ADDR_WIDTH-1:ADDR_LSB+LOG_DEPTH],
                                s_axi_awaddr[ADDR_LSB-1:0],
                                s_axi_araddr[C_AXI_ADDR_WIDTH-1:ADDR_LSB+LOG_DEPTH],
                                s_axi_araddr[ADDR_LSB-1:0]};

endmodule
